column_scheduler: RTL and testbench
===================================

COLUMN_SCHEDULER -- requirements
Module: column_scheduler

Interface
REQ-001 Parameter NUM_COLS, default 160, columns per frame (even, 2..254).
REQ-002 Parameter TIMEOUT_CYC, default 1024, maximum WAIT cycles per column; used only with the timeout macro.
REQ-003 The block SHALL use reset resetn, synchronous, active-low, on clock clock.
REQ-004 Ports (clock and reset first):
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- frame_start  in  1  frame request; sampled only in IDLE
- abort  in  1  cancels the frame in progress
- player_x  in  13 signed  player X position
- player_y  in  13 signed  player Y position
- slice_done  in  1  slice engine has finished the current column
- px_o  out  13 signed  latched player X, stable for the whole frame
- py_o  out  13 signed  latched player Y, stable for the whole frame
- col_o  out  8  current column index
- beta_o  out  10 signed  ray angle offset for the current column
- slice_start  out  1  one-cycle pulse that launches the slice engine
- frame_busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse when a frame completes
- timeout_err  out  1  sticky column-timeout flag

Function
REQ-005 The FSM SHALL have the states IDLE, LAUNCH, WAIT, ADVANCE and DONE, and all outputs SHALL be registered or decoded Moore-style from state.
REQ-006 In IDLE with frame_start=1, the block SHALL latch player_x/player_y into px_o/py_o, clear col_o to 0 and enter LAUNCH on the next edge.
REQ-007 slice_start SHALL be 1 for exactly the one cycle spent in LAUNCH, and LAUNCH SHALL always go to WAIT.
REQ-008 WAIT SHALL go to ADVANCE on the edge where slice_done=1; slice_done in any other state SHALL be ignored.
REQ-009 ADVANCE SHALL go to DONE when col_o==NUM_COLS-1; otherwise it SHALL increment col_o and go to LAUNCH.
REQ-010 DONE SHALL assert frame_done for one cycle and then return to IDLE.
REQ-011 beta_o SHALL equal col_o - NUM_COLS/2, sign-extended to 10 bits (column 0 -> -80, column 159 -> 79).
REQ-012 Column cost SHALL be 3 cycles when slice_done is high on the first WAIT cycle: LAUNCH, WAIT, ADVANCE.
REQ-013 frame_start while frame_busy=1 SHALL be ignored and not queued.
REQ-014 px_o/py_o SHALL change only on the frame_start acceptance edge, never mid-frame.
REQ-015 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with no frame_done and no further slice_start.
REQ-016 When abort and slice_done are both 1 in the same cycle, abort SHALL win; when abort and frame_start are both 1 in IDLE, the frame SHALL start.

Reset
REQ-017 On reset the block SHALL enter IDLE, set col_o=0, px_o=py_o=0, beta_o=-NUM_COLS/2, slice_start=0, frame_busy=0, frame_done=0 and timeout_err=0.
REQ-018 Reset asserted mid-frame SHALL behave as abort and also clear timeout_err.

Configuration
REQ-019 With COLUMN_SCHED_TIMEOUT_EN defined:
- a WAIT-cycle counter SHALL clear on entry to WAIT;
- when the counter reaches TIMEOUT_CYC-1 without slice_done, the block SHALL set timeout_err (sticky until reset) and go to ADVANCE, skipping the column.
REQ-020 Without COLUMN_SCHED_TIMEOUT_EN, timeout_err SHALL be tied to 0, no counter SHALL exist, and WAIT SHALL persist indefinitely.

Structure
REQ-021 A shared package SHALL hold: the NUM_COLS default, the column and beta widths, the state encoding enum, and the screen-centre constant NUM_COLS/2.
REQ-022 A single sub-module, column_counter, SHALL implement the clear, increment and terminal-count flag for col_o.

Verification
REQ-023 frame_start pulse with slice_done returned 1 cycle after each slice_start -> 160 slice_start pulses, col_o 0..159, one frame_done, 480 cycles from LAUNCH to DONE.
REQ-024 player_x=100, player_y=-50 at start, then changed mid-frame -> px_o=100, py_o=-50 held until frame_done.
REQ-025 abort at column 37 -> IDLE next cycle, no frame_done; a new frame_start restarts at col_o=0, beta_o=-80.
REQ-026 frame_start pulsed while in WAIT at column 5 -> ignored; exactly one frame_done for the frame.
REQ-027 With COLUMN_SCHED_TIMEOUT_EN and slice_done withheld on column 10 -> timeout_err=1 after 1024 WAIT cycles, col_o advances to 11, and the frame completes.

Source files
------------

// File: rtl/column_scheduler_pkg.sv
// Shared constants, state encoding and beta helper for the column scheduler.
package column_scheduler_pkg;

  localparam int NUM_COLS_DEF  = 160;
  localparam int COL_W         = 8;
  localparam int BETA_W        = 10;
  localparam int POS_W         = 13;
  localparam int SCREEN_CENTRE = NUM_COLS_DEF / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_ADVANCE,
    ST_DONE
  } sched_state_e;

  // Ray angle offset of a column relative to the screen centre, two's complement.
  function automatic logic [BETA_W-1:0] col_to_beta(input logic [COL_W-1:0] col,
                                                    input int centre);
    return BETA_W'(col) - BETA_W'(centre);
  endfunction

endpackage

// File: rtl/column_scheduler_counter.sv
// Column index register: synchronous clear, increment and terminal-count flag.
module column_counter
  import column_scheduler_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             inc,
  output logic [COL_W-1:0] count,
  output logic             last
);

  always_ff @(posedge clock) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == COL_W'(NUM_COLS - 1));

endmodule

// File: rtl/column_scheduler.sv
// Walks a frame column by column, launching the slice engine once per column.
// Optional WAIT timeout is enabled with the COLUMN_SCHED_TIMEOUT_EN macro.
module column_scheduler
  import column_scheduler_pkg::*;
#(
  parameter int NUM_COLS    = NUM_COLS_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     frame_start,
  input  logic                     abort,
  input  logic signed [POS_W-1:0]  player_x,
  input  logic signed [POS_W-1:0]  player_y,
  input  logic                     slice_done,
  output logic signed [POS_W-1:0]  px_o,
  output logic signed [POS_W-1:0]  py_o,
  output logic [COL_W-1:0]         col_o,
  output logic signed [BETA_W-1:0] beta_o,
  output logic                     slice_start,
  output logic                     frame_busy,
  output logic                     frame_done,
  output logic                     timeout_err
);

  localparam int CENTRE = (NUM_COLS == NUM_COLS_DEF) ? SCREEN_CENTRE : NUM_COLS / 2;

  // Slice handshake: slice_start is a one-cycle launch with no backpressure;
  // the engine answers with slice_done, which is only sampled while in WAIT.
  sched_state_e state, state_n;
  logic         accept;
  logic         col_clear;
  logic         col_inc;
  logic         col_last;
  logic         wait_expired;

  column_counter #(.NUM_COLS(NUM_COLS)) u_col (
    .clock  (clock),
    .resetn (resetn),
    .clear  (col_clear),
    .inc    (col_inc),
    .count  (col_o),
    .last   (col_last)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= ST_IDLE;
      px_o  <= '0;
      py_o  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        px_o <= player_x;
        py_o <= player_y;
      end
    end
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    col_clear = 1'b0;
    col_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_start) begin
          accept    = 1'b1;
          col_clear = 1'b1;
          state_n   = ST_LAUNCH;
        end
      end
      ST_LAUNCH:  state_n = ST_WAIT;
      ST_WAIT: begin
        if (slice_done || wait_expired) state_n = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (col_last) begin
          state_n = ST_DONE;
        end else begin
          col_inc = 1'b1;
          state_n = ST_LAUNCH;
        end
      end
      ST_DONE:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    // Abort overrides everything once a frame is in flight.
    if (abort && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      col_inc = 1'b0;
    end
  end

`ifdef COLUMN_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  always_ff @(posedge clock) begin
    if (!resetn || (state != ST_WAIT)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign wait_expired = (state == ST_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      timeout_q <= 1'b0;
    end else if (wait_expired && !slice_done && !abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wait_expired = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  assign slice_start = (state == ST_LAUNCH);
  assign frame_busy  = (state != ST_IDLE);
  assign frame_done  = (state == ST_DONE);
  assign beta_o      = col_to_beta(col_o, CENTRE);

endmodule

// File: tb/tb_column_scheduler.sv
// Self-checking bench for column_scheduler: scoreboard of expected column/beta per launch.
`timescale 1ns/1ps
module tb_column_scheduler;

  localparam int NUM_COLS    = 160;
  localparam int TIMEOUT_CYC = 1024;

  logic               clock;
  logic               resetn;
  logic               frame_start;
  logic               abort;
  logic signed [12:0] player_x;
  logic signed [12:0] player_y;
  logic               slice_done;
  logic signed [12:0] px_o;
  logic signed [12:0] py_o;
  logic [7:0]         col_o;
  logic signed [9:0]  beta_o;
  logic               slice_start;
  logic               frame_busy;
  logic               frame_done;
  logic               timeout_err;

  column_scheduler #(.NUM_COLS(NUM_COLS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_start (frame_start),
    .abort       (abort),
    .player_x    (player_x),
    .player_y    (player_y),
    .slice_done  (slice_done),
    .px_o        (px_o),
    .py_o        (py_o),
    .col_o       (col_o),
    .beta_o      (beta_o),
    .slice_start (slice_start),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic signed [12:0] exp_px = '0;
  logic signed [12:0] exp_py = '0;
  int cyc = 0;
  int launch_cyc = 0;
  int done_cyc = 0;
  int n_done = 0;
  int n_start = 0;
  int resp_max = 0;
  int skip_col = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  logic [17:0] exp_e;
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (resetn) begin
        if (slice_start) begin
          n_start++;
          if (col_o == 8'd0) launch_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("stray_slice_start", 32'd1, 32'd0);
          end else begin
            exp_e = exp_q.pop_front();
            check("col_beta", {14'b0, beta_o, col_o}, {14'b0, exp_e});
          end
          check("px_hold", px_o, exp_px);
          check("py_hold", py_o, exp_py);
        end
        if (frame_done) begin
          n_done++;
          done_cyc = cyc;
        end
      end
    end
  end

  // slice engine model: answers after 0..resp_max WAIT cycles, never for skip_col
  bit armed = 0;
  int dly = 0;
  initial begin
    slice_done = 1'b0;
    forever begin
      @(negedge clock);
      slice_done = 1'b0;
      if (armed) begin
        if (dly == 0) begin
          slice_done = 1'b1;
          armed = 0;
        end else begin
          dly--;
        end
      end
      if (resetn && slice_start && (int'(col_o) != skip_col)) begin
        armed = 1;
        dly = $urandom_range(0, resp_max);
      end
    end
  end

  // driver tasks
  task automatic start_frame(input logic signed [12:0] x, input logic signed [12:0] y,
                             input logic ab);
    logic [9:0] b;
    @(negedge clock);
    frame_start = 1'b1;
    abort       = ab;
    player_x    = x;
    player_y    = y;
    exp_px      = x;
    exp_py      = y;
    for (int c = 0; c < NUM_COLS; c++) begin
      b = 10'(c) - 10'(NUM_COLS / 2);
      exp_q.push_back({b, 8'(c)});
    end
    @(negedge clock);
    frame_start = 1'b0;
    abort       = 1'b0;
  endtask

  task automatic wait_launch(input int col, input int budget, output int waited);
    bit found = 0;
    waited = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      waited++;
      if (slice_start && (int'(col_o) == col)) found = 1;
    end
    if (!found) check("launch_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      if (frame_done) found = 1;
    end
    if (!found) check("frame_done_wait_expired", 32'd0, 32'd1);
  endtask

  int d0;
  int w;
  logic signed [12:0] rx, ry;

  initial begin
    frame_start = 1'b0;
    abort       = 1'b0;
    player_x    = '0;
    player_y    = '0;
    resetn      = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_col", col_o, 0);
    check("rst_beta", beta_o, -80);
    check("rst_px", px_o, 0);
    check("rst_py", py_o, 0);
    check("rst_slice_start", slice_start, 0);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_timeout", timeout_err, 0);
    resetn = 1'b1;
    @(negedge clock);

    // full frame at minimum column cost, player moves mid-frame
    resp_max = 0;
    n_start = 0;
    n_done = 0;
    start_frame(13'sd100, -13'sd50, 1'b0);
    wait_launch(20, 200, w);
    player_x = 13'(int'($urandom_range(0, 4000)));
    player_y = 13'(int'($urandom_range(0, 4000)));
    wait_done(1000);
    @(negedge clock);
    check("frame1_cycles", done_cyc - launch_cyc, 480);
    check("frame1_starts", n_start, NUM_COLS);
    check("frame1_dones", n_done, 1);
    check("frame1_q_empty", exp_q.size(), 0);
    check("frame1_done_pulse", frame_done, 0);
    check("frame1_idle", frame_busy, 0);
    check("frame1_px_after", px_o, 100);
    check("frame1_py_after", py_o, -50);

    // abort at column 37 in the same cycle slice_done returns
    d0 = n_done;
    start_frame(13'(int'($urandom_range(0, 8000))), 13'(int'($urandom_range(0, 8000))), 1'b0);
    wait_launch(37, 200, w);
    @(negedge clock);
    abort = 1'b1;
    exp_q.delete();
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle", frame_busy, 0);
    repeat (10) @(negedge clock);
    check("abort_no_done", n_done, d0);
    start_frame(13'(int'($urandom_range(0, 8000))), 13'(int'($urandom_range(0, 8000))), 1'b0);
    wait_done(1000);
    @(negedge clock);
    check("restart_done", n_done, d0 + 1);

    // frame_start during WAIT at column 5 is dropped
    d0 = n_done;
    start_frame(-13'sd7, 13'sd321, 1'b0);
    wait_launch(5, 100, w);
    @(negedge clock);
    frame_start = 1'b1;
    player_x    = 13'sd999;
    @(negedge clock);
    frame_start = 1'b0;
    wait_done(1000);
    repeat (5) @(negedge clock);
    check("nostart_one_done", n_done, d0 + 1);
    check("nostart_not_queued", frame_busy, 0);

    // abort together with frame_start in IDLE starts the frame
    start_frame(13'sd55, -13'sd1, 1'b1);
    check("abort_start_busy", frame_busy, 1);
    wait_done(1000);

    // random slice latencies and positions
    resp_max = 3;
    for (int f = 0; f < 2; f++) begin
      rx = 13'(int'($urandom_range(0, 8191)));
      ry = 13'(int'($urandom_range(0, 8191)));
      d0 = n_done;
      start_frame(rx, ry, 1'b0);
      wait_done(NUM_COLS * 7);
      @(negedge clock);
      check("rand_done", n_done, d0 + 1);
      check("rand_q_empty", exp_q.size(), 0);
    end
    resp_max = 0;
    check("no_timeout_normal", timeout_err, 0);

    // reset mid-frame behaves as abort
    d0 = n_done;
    start_frame(13'sd12, 13'sd34, 1'b0);
    wait_launch(50, 300, w);
    @(negedge clock);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrst_busy", frame_busy, 0);
    check("midrst_col", col_o, 0);
    check("midrst_beta", beta_o, -80);
    check("midrst_px", px_o, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("midrst_no_done", n_done, d0);

`ifdef COLUMN_SCHED_TIMEOUT_EN
    // column 10 never answered: timeout skips it and the frame finishes
    d0 = n_done;
    skip_col = 10;
    start_frame(13'sd1, 13'sd2, 1'b0);
    wait_launch(10, 200, w);
    wait_launch(11, TIMEOUT_CYC + 100, w);
    check("timeout_col_cost", w, TIMEOUT_CYC + 2);
    check("timeout_set", timeout_err, 1);
    wait_done(1000);
    @(negedge clock);
    skip_col = -1;
    check("timeout_frame_done", n_done, d0 + 1);
    check("timeout_sticky", timeout_err, 1);
    resetn = 1'b0;
    @(negedge clock);
    check("timeout_rst_clear", timeout_err, 0);
    resetn = 1'b1;
    @(negedge clock);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
